hls_ap_ctrl_driver: RTL and testbench



---
 rtl/hls_ap_ctrl_driver.sv | 194 +++++++++++++++++++
 tb/tb_hls_ap_ctrl_driver.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_ap_ctrl_driver.sv
// hls_ap_ctrl_driver
// Initiator for the HLS ap_ctrl_hs block-level handshake. Runs the attached
// core for num_runs back-to-back invocations, records how many completed and
// the latency of the most recent one, and aborts the batch with a sticky
// timeout_err if any single invocation exceeds TIMEOUT_CYCLES.
//
// Ports:
//   sys_clock      in   system clock, rising edge
//   sys_resetn     in   asynchronous active-low reset
//   go             in   one-cycle batch request (ignored while busy)
//   num_runs       in   invocations per batch, latched on accepted go
//   ap_start       out  start request to the HLS core
//   ap_ready       in   core has consumed its inputs
//   ap_done        in   core completion pulse
//   ap_idle        in   core is idle
//   busy           out  batch in progress
//   batch_done     out  one-cycle pulse on error-free batch completion
//   timeout_err    out  sticky timeout flag, cleared by the next accepted go
//   runs_completed out  ap_done pulses counted in the current/last batch
//   last_latency   out  cycles of the most recent completed invocation
module hls_ap_ctrl_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned LAT_W          = 16
) (
  input  logic             sys_clock,
  input  logic             sys_resetn,
  input  logic             go,
  input  logic [15:0]      num_runs,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic             busy,
  output logic             batch_done,
  output logic             timeout_err,
  output logic [15:0]      runs_completed,
  output logic [LAT_W-1:0] last_latency
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_IDLE = 3'd1,
    S_START     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_ERROR     = 3'd4
  } state_t;

  localparam logic [LAT_W-1:0] CNT_LAST = LAT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAT_W-1:0] CNT_MAX  = {LAT_W{1'b1}};

  state_t           state_q, state_d;
  logic             ap_start_q, ap_start_d;
  logic             busy_q, busy_d;
  logic             batch_done_q, batch_done_d;
  logic             timeout_err_q, timeout_err_d;
  logic [15:0]      runs_q, runs_d;
  logic [15:0]      num_runs_q, num_runs_d;
  logic [LAT_W-1:0] last_lat_q, last_lat_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  logic [LAT_W-1:0] cnt_inc_s;
  logic [LAT_W-1:0] lat_val_s;
  logic             more_runs_s;
  logic             run_done_s;

  // One counter serves both timeout and latency: it is cleared on START entry,
  // so in START/WAIT_DONE it equals (cycle - S). Both uses saturate.
  assign cnt_inc_s   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(LAT_W-1){1'b0}}, 1'b1};
  assign lat_val_s   = cnt_inc_s;
  // 17-bit compare so runs_q = 16'hFFFF cannot wrap into a false "more runs".
  assign more_runs_s = ({1'b0, runs_q} + 17'd1) < {1'b0, num_runs_q};

  // State and output registers; all outputs come straight from flops.
  always_ff @(posedge sys_clock or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q       <= S_IDLE;
      ap_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      batch_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      runs_q        <= 16'd0;
      num_runs_q    <= 16'd0;
      last_lat_q    <= {LAT_W{1'b0}};
      cnt_q         <= {LAT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      ap_start_q    <= ap_start_d;
      busy_q        <= busy_d;
      batch_done_q  <= batch_done_d;
      timeout_err_q <= timeout_err_d;
      runs_q        <= runs_d;
      num_runs_q    <= num_runs_d;
      last_lat_q    <= last_lat_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    batch_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    runs_d        = runs_q;
    num_runs_d    = num_runs_q;
    last_lat_d    = last_lat_q;
    cnt_d         = cnt_q;
    run_done_s    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = {LAT_W{1'b0}};
        if (go) begin
          runs_d        = 16'd0;
          timeout_err_d = 1'b0;
          if (num_runs == 16'd0) begin
            batch_done_d = 1'b1;
          end else begin
            num_runs_d = num_runs;
            state_d    = ap_idle ? S_START : S_WAIT_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (ap_idle) begin
          state_d = S_START;
          cnt_d   = {LAT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_ERROR;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_START: begin
        if (ap_ready && ap_done) begin
          run_done_s = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_ERROR;
          timeout_err_d = 1'b1;
        end else if (ap_ready) begin
          state_d = S_WAIT_DONE;
          cnt_d   = cnt_inc_s;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_WAIT_DONE: begin
        if (ap_done) begin
          run_done_s = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_ERROR;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_ERROR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion: back-to-back restart re-enters START with a fresh counter.
    if (run_done_s) begin
      runs_d     = runs_q + 16'd1;
      last_lat_d = lat_val_s;
      cnt_d      = {LAT_W{1'b0}};
      if (more_runs_s) begin
        state_d = S_START;
      end else begin
        state_d      = S_IDLE;
        batch_done_d = 1'b1;
      end
    end else begin
      runs_d = runs_d;
    end

    ap_start_d = (state_d == S_START);
    busy_d     = (state_d == S_WAIT_IDLE) || (state_d == S_START) ||
                 (state_d == S_WAIT_DONE);
  end

  assign ap_start       = ap_start_q;
  assign busy           = busy_q;
  assign batch_done     = batch_done_q;
  assign timeout_err    = timeout_err_q;
  assign runs_completed = runs_q;
  assign last_latency   = last_lat_q;

endmodule

// File: tb/tb_hls_ap_ctrl_driver.sv
// Self-checking bench for hls_ap_ctrl_driver (TIMEOUT_CYCLES=16).
module tb_hls_ap_ctrl_driver;

  logic        sys_clock = 1'b0;
  logic        sys_resetn;
  logic        go;
  logic [15:0] num_runs;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_idle;
  logic        busy;
  logic        batch_done;
  logic        timeout_err;
  logic [15:0] runs_completed;
  logic [15:0] last_latency;

  int errs   = 0;
  int checks = 0;

  // core model state
  bit core_en;
  int rdy_lat, done_lat, k;
  bit in_run;

  hls_ap_ctrl_driver #(.TIMEOUT_CYCLES(16), .LAT_W(16)) dut (
    .sys_clock     (sys_clock),
    .sys_resetn    (sys_resetn),
    .go            (go),
    .num_runs      (num_runs),
    .ap_start      (ap_start),
    .ap_ready      (ap_ready),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .busy          (busy),
    .batch_done    (batch_done),
    .timeout_err   (timeout_err),
    .runs_completed(runs_completed),
    .last_latency  (last_latency)
  );

  always #4 sys_clock = ~sys_clock;

  typedef struct {
    logic        go;
    logic [15:0] nr;
    logic        rdy;
    logic        done;
    logic        idle;
    logic        e_start;
    logic        e_busy;
    logic        e_bd;
    logic        e_terr;
    logic [15:0] e_runs;
    logic [15:0] e_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic core_cfg(input bit en, input int r, input int d);
    core_en  = en;
    rdy_lat  = r;
    done_lat = d;
    in_run   = 1'b0;
    k        = 0;
    ap_ready = 1'b0;
    ap_done  = 1'b0;
  endtask

  // One clock: core model drives ready/done from its invocation age, then
  // outputs are sampled 1 ns after the edge.
  task automatic tick();
    if (core_en) begin
      if (ap_start && !in_run) begin
        in_run = 1'b1;
        k      = 0;
      end
      ap_ready = in_run && (k == rdy_lat - 1);
      ap_done  = in_run && (done_lat != 0) && (k == done_lat - 1);
    end
    @(posedge sys_clock);
    #1;
    if (core_en && in_run) begin
      if (ap_done) in_run = 1'b0;
      else k++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int st_cnt, first_j, bd_cnt;
    bit seen, done_prev, found;

    sys_resetn = 1'b0;
    go         = 1'b0;
    num_runs   = 16'd0;
    ap_idle    = 1'b1;
    core_cfg(1'b0, 1, 1);

    // num_runs=0, then single-cycle core with num_runs=5, then stray handshakes in IDLE
    vecs[0] = '{1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0};
    vecs[1] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[2] = '{1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[3] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1};
    vecs[4] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 16'd1};
    vecs[5] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 16'd1};
    vecs[6] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd4, 16'd1};
    vecs[7] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5, 16'd1};
    vecs[8] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 16'd1};
    vecs[9] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 16'd1};

    #22;
    chk("rst.ap_start", ap_start, 0);
    chk("rst.busy", busy, 0);
    chk("rst.batch_done", batch_done, 0);
    chk("rst.timeout_err", timeout_err, 0);
    chk("rst.runs", runs_completed, 0);
    chk("rst.latency", last_latency, 0);
    sys_resetn = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      go       = vecs[i].go;
      num_runs = vecs[i].nr;
      ap_ready = vecs[i].rdy;
      ap_done  = vecs[i].done;
      ap_idle  = vecs[i].idle;
      tick();
      chk($sformatf("vec%0d.ap_start", i), ap_start, vecs[i].e_start);
      chk($sformatf("vec%0d.busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d.batch_done", i), batch_done, vecs[i].e_bd);
      chk($sformatf("vec%0d.timeout_err", i), timeout_err, vecs[i].e_terr);
      chk($sformatf("vec%0d.runs", i), runs_completed, vecs[i].e_runs);
      chk($sformatf("vec%0d.latency", i), last_latency, vecs[i].e_lat);
    end
    go = 1'b0;
    ap_ready = 1'b0;
    ap_done = 1'b0;

    // Core: ready 3 cycles, done 10 cycles after ap_start; one run
    core_cfg(1'b1, 3, 10);
    go = 1'b1; num_runs = 16'd1; tick(); go = 1'b0;
    chk("r1.start_after_go", ap_start, 1);
    chk("r1.busy_after_go", busy, 1);
    st_cnt = ap_start; seen = 1'b0; done_prev = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      st_cnt += ap_start;
      if (batch_done) begin
        seen = 1'b1;
        done_prev = ap_done;
      end
    end
    chk("r1.batch_done_seen", seen, 1);
    chk("r1.bd_after_done", done_prev, 1);
    chk("r1.start_cycles", st_cnt, 3);
    chk("r1.latency", last_latency, 10);
    chk("r1.runs", runs_completed, 1);
    chk("r1.busy_at_bd", busy, 0);
    tick();
    chk("r1.bd_single", batch_done, 0);

    // Core never completes: timeout 16 cycles after ap_start rise
    core_cfg(1'b1, 3, 0);
    go = 1'b1; num_runs = 16'd2; tick(); go = 1'b0;
    chk("to.start_rise", ap_start, 1);
    first_j = -1; seen = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      tick();
      if (batch_done) seen = 1'b1;
      if (timeout_err && first_j < 0) begin
        first_j = j;
        chk("to.start_low", ap_start, 0);
        chk("to.busy_low", busy, 0);
      end
    end
    chk("to.cycle", first_j, 16);
    chk("to.no_batch_done", seen, 0);
    chk("to.sticky", timeout_err, 1);
    chk("to.runs", runs_completed, 0);

    // Next go clears timeout_err; single-cycle core completes one run
    core_cfg(1'b1, 1, 1);
    go = 1'b1; num_runs = 16'd1; tick(); go = 1'b0;
    chk("clr.timeout_err", timeout_err, 0);
    tick();
    chk("clr.batch_done", batch_done, 1);
    chk("clr.latency", last_latency, 1);

    // ap_idle low for 7 cycles after go
    ap_idle = 1'b0;
    go = 1'b1; num_runs = 16'd1; tick(); go = 1'b0;
    st_cnt = ap_start;
    for (int i = 0; i < 6; i++) begin
      tick();
      st_cnt += ap_start;
    end
    chk("idle.start_held_low", st_cnt, 0);
    chk("idle.busy", busy, 1);
    ap_idle = 1'b1; tick();
    chk("idle.start_after_idle", ap_start, 1);
    tick();
    chk("idle.batch_done", batch_done, 1);

    // ap_idle held low past the timeout
    ap_idle = 1'b0;
    go = 1'b1; num_runs = 16'd1; tick(); go = 1'b0;
    first_j = -1;
    for (int j = 1; j <= 30; j++) begin
      tick();
      if (timeout_err && first_j < 0) first_j = j;
    end
    chk("idle_to.cycle", first_j, 16);
    chk("idle_to.busy", busy, 0);
    ap_idle = 1'b1;

    // Go while busy is ignored
    core_cfg(1'b1, 3, 10);
    go = 1'b1; num_runs = 16'd3; tick(); go = 1'b0;
    bd_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 5) begin
        go = 1'b1; num_runs = 16'd7;
      end else begin
        go = 1'b0;
      end
      tick();
      if (batch_done) begin
        bd_cnt++;
        break;
      end
    end
    go = 1'b0;
    chk("busygo.batch_done", bd_cnt, 1);
    chk("busygo.runs", runs_completed, 3);
    tick(); tick();
    chk("busygo.start_after", ap_start, 0);
    chk("busygo.busy_after", busy, 0);

    // Reset during WAIT_DONE of run 2 of 4
    core_cfg(1'b1, 3, 10);
    go = 1'b1; num_runs = 16'd4; tick(); go = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (runs_completed == 16'd1 && !ap_start && busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstmid.reached", found, 1);
    #2 sys_resetn = 1'b0;
    #1;
    chk("rstmid.ap_start", ap_start, 0);
    chk("rstmid.busy", busy, 0);
    chk("rstmid.runs", runs_completed, 0);
    #2 sys_resetn = 1'b1;
    core_cfg(1'b0, 1, 1);
    ap_done = 1'b1; tick();
    ap_done = 1'b0; tick();
    chk("rstmid.stray_runs", runs_completed, 0);
    chk("rstmid.stray_start", ap_start, 0);
    chk("rstmid.stray_bd", batch_done, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
